// File: rtl/reed_solomon_pkg.sv
// Shared GF(2^8) types and elaboration-time helpers for the Reed-Solomon encoder.
package reed_solomon_pkg;

  localparam int unsigned SYM_W      = 8;
  localparam int unsigned MAX_PARITY = 64;
  localparam logic [8:0]  GF_POLY    = 9'h11D;

  typedef logic [SYM_W-1:0] rs_sym_t;
  typedef logic [MAX_PARITY-1:0][SYM_W-1:0] rs_gen_t;

  typedef enum logic {RS_ENC_DATA, RS_ENC_PARITY} rs_enc_state_t;

  // Shift-and-add multiply, reducing by the field polynomial each step.
  function automatic rs_sym_t gf_mul(input rs_sym_t a, input rs_sym_t b);
    rs_sym_t acc;
    rs_sym_t x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0]) : {x[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Coefficients g[0..nsym-1] of prod(x + alpha^i); the monic leading term is implied.
  function automatic rs_gen_t gf_gen_poly(input int unsigned nsym);
    rs_sym_t g [MAX_PARITY+1];
    rs_sym_t root;
    rs_gen_t gen;
    for (int k = 0; k <= int'(MAX_PARITY); k++) g[k] = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < int'(MAX_PARITY); i++) begin
      if (i < int'(nsym)) begin
        for (int j = int'(MAX_PARITY); j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
        g[0] = gf_mul(g[0], root);
        root = gf_mul(root, 8'h02);
      end
    end
    gen = '0;
    for (int k = 0; k < int'(MAX_PARITY); k++) gen[k] = (k < int'(nsym)) ? g[k] : '0;
    return gen;
  endfunction

endpackage

// File: rtl/reed_solomon_gf_mul_const.sv
// Combinational GF(2^8) multiply by a constant fixed at elaboration.
module reed_solomon_gf_mul_const
  import reed_solomon_pkg::*;
#(
  parameter rs_sym_t COEF = 8'h01
) (
  input  rs_sym_t a,
  output rs_sym_t product_c
);

  assign product_c = gf_mul(a, COEF);

endmodule

// File: rtl/reed_solomon_encoder.sv
// Byte-serial systematic RS encoder: message bytes pass straight through, then LFSR parity.
module reed_solomon_encoder
  import reed_solomon_pkg::*;
#(
  parameter int unsigned MSG_SYMS    = 223,
  parameter int unsigned PARITY_SYMS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [31:0] codeword_count
);

  localparam rs_gen_t    GEN      = gf_gen_poly(PARITY_SYMS);
  localparam logic [7:0] LAST_MSG = 8'(MSG_SYMS - 1);
  localparam logic [7:0] LAST_PAR = 8'(PARITY_SYMS - 1);

  rs_enc_state_t state, state_next;
  rs_sym_t       parity  [PARITY_SYMS];
  rs_sym_t       fb_prod [PARITY_SYMS];
  rs_sym_t       fb;
  logic [7:0]    sym_cnt;
  logic          shift_msg;
  logic          shift_par;
  logic          cnt_last;

  assign fb = in_data ^ parity[PARITY_SYMS-1];

  // One constant multiplier per generator tap, all fed by the feedback byte.
  for (genvar i = 0; i < int'(PARITY_SYMS); i++) begin : g_tap
    reed_solomon_gf_mul_const #(.COEF(GEN[i])) u_mul (
      .a        (fb),
      .product_c(fb_prod[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RS_ENC_DATA;
    else       state <= state_next;
  end

  // Handshake, output mux and next-state selection.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    shift_msg  = 1'b0;
    shift_par  = 1'b0;
    cnt_last   = 1'b0;
    case (state)
      RS_ENC_DATA: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data;
        cnt_last  = (sym_cnt == LAST_MSG);
        if (in_valid && out_ready) begin
          shift_msg = 1'b1;
          if (cnt_last) state_next = RS_ENC_PARITY;
        end
      end
      RS_ENC_PARITY: begin
        out_valid = 1'b1;
        out_data  = parity[PARITY_SYMS-1];
        cnt_last  = (sym_cnt == LAST_PAR);
        out_last  = cnt_last;
        if (out_ready) begin
          shift_par = 1'b1;
          if (cnt_last) state_next = RS_ENC_DATA;
        end
      end
      default: state_next = RS_ENC_DATA;
    endcase
  end

  // Parity LFSR: divide while the message streams, then shift out highest term first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(PARITY_SYMS); i++) parity[i] <= '0;
    end else if (shift_msg) begin
      parity[0] <= fb_prod[0];
      for (int i = 1; i < int'(PARITY_SYMS); i++) parity[i] <= parity[i-1] ^ fb_prod[i];
    end else if (shift_par) begin
      parity[0] <= '0;
      for (int i = 1; i < int'(PARITY_SYMS); i++) parity[i] <= parity[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_cnt        <= '0;
      codeword_count <= '0;
    end else begin
      if (shift_msg || shift_par) sym_cnt <= cnt_last ? 8'd0 : sym_cnt + 8'd1;
      if (shift_par && cnt_last)  codeword_count <= codeword_count + 32'd1;
    end
  end

endmodule
